// File: rtl/avmm_burst_master.sv
// Avalon-MM burst master: issues one write or read burst (1..16 beats) per
// accepted local command. Write beats are pulled from a valid/ready stream,
// read beats are returned on a registered valid-only stream.
//
// Optional read watchdog: define AVMM_BURST_MASTER_TIMEOUT_EN to abort a read
// burst after TIMEOUT_CYCLES consecutive cycles without a returned beat.

module avmm_burst_master #(
    parameter int unsigned DW             = 32,
    parameter int unsigned AW             = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk_i,
    input  logic          rst_n,
    // Local command interface
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_address,
    input  logic [4:0]    cmd_burstcount,
    // Write beat stream
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    // Read beat stream
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    // Status
    output logic          done_o,
    output logic          err_o,
    output logic          busy_o,
    // Avalon-MM master port
    output logic [AW-1:0] avm_address,
    output logic          avm_beginbursttransfer,
    output logic [4:0]    avm_burstcount,
    output logic          avm_read,
    output logic          avm_write,
    output logic [DW-1:0] avm_writedata,
    input  logic          avm_readdatavalid,
    input  logic [DW-1:0] avm_readdata,
    input  logic          avm_waitrequest
);

    typedef enum logic [1:0] {
        StIdle,
        StWrBurst,
        StRdReq,
        StRdData
    } state_e;

    state_e        state_q;
    logic [4:0]    beat_cnt_q;
    logic          cmd_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic [AW-1:0] avm_address_q;
    logic [4:0]    avm_burstcount_q;
    logic          avm_read_q;
    logic          begin_q;

    logic          cmd_accept;
    logic          cmd_legal;
    logic          wr_beat;
    logic          last_beat;

`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
    // Watchdog only needs to represent 0..TIMEOUT_CYCLES-1.
    localparam int unsigned WdW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [WdW-1:0] wd_q;
    logic           wd_expired;

    assign wd_expired = (wd_q == WdW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Command handshake and burst beat qualifiers.
    assign cmd_accept = cmd_valid && cmd_ready_q;
    assign cmd_legal  = (cmd_burstcount != 5'd0) && (cmd_burstcount <= 5'd16);
    assign wr_beat    = (state_q == StWrBurst) && wr_valid && !avm_waitrequest;
    assign last_beat  = (beat_cnt_q == (avm_burstcount_q - 5'd1));

    // Write path is a pass-through of the local stream while bursting.
    assign avm_write     = (state_q == StWrBurst) && wr_valid;
    assign wr_ready      = wr_beat;
    assign avm_writedata = wr_data;

    assign cmd_ready              = cmd_ready_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign err_o                  = err_q;
    assign rd_valid               = rd_valid_q;
    assign rd_data                = rd_data_q;
    assign avm_address            = avm_address_q;
    assign avm_burstcount         = avm_burstcount_q;
    assign avm_read               = avm_read_q;
    assign avm_beginbursttransfer = begin_q;

    // Burst FSM with all registered outputs; pulses default low every cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            beat_cnt_q       <= 5'd0;
            cmd_ready_q      <= 1'b1;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= '0;
            avm_address_q    <= '0;
            avm_burstcount_q <= 5'd0;
            avm_read_q       <= 1'b0;
            begin_q          <= 1'b0;
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
            wd_q             <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            begin_q    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (cmd_accept) begin
                        if (cmd_legal) begin
                            avm_address_q    <= cmd_address;
                            avm_burstcount_q <= cmd_burstcount;
                            beat_cnt_q       <= 5'd0;
                            begin_q          <= 1'b1;
                            cmd_ready_q      <= 1'b0;
                            busy_q           <= 1'b1;
                            if (cmd_write) begin
                                state_q <= StWrBurst;
                            end else begin
                                state_q    <= StRdReq;
                                avm_read_q <= 1'b1;
                            end
                        end else begin
                            // Rejected command: report it without touching the bus.
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end

                StWrBurst: begin
                    if (wr_beat) begin
                        if (last_beat) begin
                            state_q     <= StIdle;
                            beat_cnt_q  <= 5'd0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 5'd1;
                        end
                    end
                end

                StRdReq: begin
                    if (!avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        state_q    <= StRdData;
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
                        wd_q       <= '0;
`endif
                    end
                end

                StRdData: begin
                    if (avm_readdatavalid) begin
                        rd_data_q  <= avm_readdata;
                        rd_valid_q <= 1'b1;
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
                        wd_q       <= '0;
`endif
                        if (last_beat) begin
                            state_q     <= StIdle;
                            beat_cnt_q  <= 5'd0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 5'd1;
                        end
                    end
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
                    else if (wd_expired) begin
                        // Slave went quiet: abandon the remaining beats.
                        state_q     <= StIdle;
                        beat_cnt_q  <= 5'd0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WdW'(1);
                    end
`endif
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_burst_master.sv
// Self-checking bench for avmm_burst_master: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// transaction-level model of the burst protocol.

module tb_avmm_burst_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [4:0]    cmd_burstcount;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done_o;
    logic          err_o;
    logic          busy_o;
    logic [AW-1:0] avm_address;
    logic          avm_beginbursttransfer;
    logic [4:0]    avm_burstcount;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_readdatavalid;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    always #5 clk = ~clk;

    avmm_burst_master #(
        .DW             (DW),
        .AW             (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i                  (clk),
        .rst_n                  (rst_n),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_write              (cmd_write),
        .cmd_address            (cmd_address),
        .cmd_burstcount         (cmd_burstcount),
        .wr_data                (wr_data),
        .wr_valid               (wr_valid),
        .wr_ready               (wr_ready),
        .rd_data                (rd_data),
        .rd_valid               (rd_valid),
        .done_o                 (done_o),
        .err_o                  (err_o),
        .busy_o                 (busy_o),
        .avm_address            (avm_address),
        .avm_beginbursttransfer (avm_beginbursttransfer),
        .avm_burstcount         (avm_burstcount),
        .avm_read               (avm_read),
        .avm_write              (avm_write),
        .avm_writedata          (avm_writedata),
        .avm_readdatavalid      (avm_readdatavalid),
        .avm_readdata           (avm_readdata),
        .avm_waitrequest        (avm_waitrequest)
    );

    // Transaction-level model: one outstanding burst, counted in beats.
    logic          m_busy;
    logic          m_wr;
    logic          m_req;
    logic          m_first;
    logic          m_done;
    logic          m_err;
    logic          m_rdv;
    logic [DW-1:0] m_rdd;
    logic [AW-1:0] m_addr;
    int            m_len;
    int            m_beats;
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
    int            m_idle;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_wr    <= 1'b0;
            m_req   <= 1'b0;
            m_first <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_rdv   <= 1'b0;
            m_rdd   <= '0;
            m_addr  <= '0;
            m_len   <= 0;
            m_beats <= 0;
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
            m_idle  <= 0;
`endif
        end else begin
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_rdv   <= 1'b0;
            m_first <= 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    if (cmd_burstcount == 5'd0 || cmd_burstcount > 5'd16) begin
                        m_done <= 1'b1;
                        m_err  <= 1'b1;
                    end else begin
                        m_busy  <= 1'b1;
                        m_wr    <= cmd_write;
                        m_req   <= !cmd_write;
                        m_addr  <= cmd_address;
                        m_len   <= int'(cmd_burstcount);
                        m_beats <= 0;
                        m_first <= 1'b1;
                    end
                end
            end else if (m_wr) begin
                if (wr_valid && !avm_waitrequest) begin
                    m_beats <= m_beats + 1;
                    if (m_beats + 1 == m_len) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                    end
                end
            end else if (m_req) begin
                if (!avm_waitrequest) begin
                    m_req <= 1'b0;
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
                    m_idle <= 0;
`endif
                end
            end else if (avm_readdatavalid) begin
                m_rdv   <= 1'b1;
                m_rdd   <= avm_readdata;
                m_beats <= m_beats + 1;
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
                m_idle  <= 0;
`endif
                if (m_beats + 1 == m_len) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else begin
`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
                m_idle <= m_idle + 1;
                if (m_idle + 1 == TO) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_err  <= 1'b1;
                end
`endif
            end
        end
    end

    int            n_checks = 0;
    int            n_err = 0;
    logic [15:0]   h_write, h_read, h_begin, h_done, h_err, h_rdv, h_busy;
    logic [DW-1:0] obs_wr[$];
    logic [DW-1:0] obs_rd[$];
    int            done_cnt = 0;
    int            addr_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic compare_cycle();
        logic exp_w;
        if (!rst_n) return;
        exp_w = m_busy && m_wr && wr_valid;
        check("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
        check("busy_o", 64'(busy_o), 64'(m_busy));
        check("done_o", 64'(done_o), 64'(m_done));
        check("err_o", 64'(err_o), 64'(m_err));
        check("avm_write", 64'(avm_write), 64'(exp_w));
        check("wr_ready", 64'(wr_ready), 64'(exp_w && !avm_waitrequest));
        check("avm_read", 64'(avm_read), 64'(m_busy && !m_wr && m_req));
        check("beginburst", 64'(avm_beginbursttransfer), 64'(m_first));
        check("rd_valid", 64'(rd_valid), 64'(m_rdv));
        check("avm_writedata", 64'(avm_writedata), 64'(wr_data));
        if (m_rdv) check("rd_data", 64'(rd_data), 64'(m_rdd));
        if (m_busy) begin
            check("avm_address", 64'(avm_address), 64'(m_addr));
            check("avm_burstcount", 64'(avm_burstcount), 64'(m_len));
        end
    endtask

    // One clock cycle: compare mid-cycle, record history, then step to the
    // next cycle's input-drive point.
    task automatic tick(input int c);
        @(negedge clk);
        compare_cycle();
        if (c >= 0 && c < 16) begin
            h_write[c] = avm_write;
            h_read[c]  = avm_read;
            h_begin[c] = avm_beginbursttransfer;
            h_done[c]  = done_o;
            h_err[c]   = err_o;
            h_rdv[c]   = rd_valid;
            h_busy[c]  = busy_o;
        end
        if (avm_write && !avm_waitrequest) obs_wr.push_back(avm_writedata);
        if (rd_valid) obs_rd.push_back(rd_data);
        if (done_o) done_cnt++;
        if (busy_o && (avm_address != 16'h0010 || avm_burstcount != 5'd4)) addr_bad++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        h_write = '0; h_read = '0; h_begin = '0; h_done = '0;
        h_err = '0; h_rdv = '0; h_busy = '0;
        obs_wr.delete();
        obs_rd.delete();
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_burstcount = 5'd0;
        wr_data = '0; wr_valid = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        avm_waitrequest = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        check({tag, "_avm_read"}, 64'(avm_read), 64'd0);
        check({tag, "_avm_write"}, 64'(avm_write), 64'd0);
        check({tag, "_begin"}, 64'(avm_beginbursttransfer), 64'd0);
        check({tag, "_address"}, 64'(avm_address), 64'd0);
        check({tag, "_burstcount"}, 64'(avm_burstcount), 64'd0);
    endtask

    initial begin
        int base;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write 4 beats, no stalls.
        clear_hist();
        base = done_cnt;
        for (int c = 0; c < 8; c++) begin
            cmd_valid = (c == 0); cmd_write = 1'b1; cmd_address = 16'h0010;
            cmd_burstcount = 5'd4; wr_valid = 1'b1;
            wr_data = 32'h0000_00A0 + 32'(m_busy ? m_beats : 0);
            tick(c);
        end
        check("wr1_write_cycles", 64'(h_write), 64'h001E);
        check("wr1_begin_cycles", 64'(h_begin), 64'h0002);
        check("wr1_done_cycles", 64'(h_done), 64'h0020);
        check("wr1_err_cycles", 64'(h_err), 64'h0000);
        check("wr1_beats", 64'(obs_wr.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_wr.size(); i++)
            check("wr1_data", 64'(obs_wr[i]), 64'(32'hA0 + 32'(i)));

        // Same write with stalls and a wr_valid bubble.
        idle_inputs();
        clear_hist();
        base = done_cnt;
        addr_bad = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = (c == 0); cmd_write = 1'b1; cmd_address = 16'h0010;
            cmd_burstcount = 5'd4; wr_valid = (c != 5);
            avm_waitrequest = (c == 2 || c == 3);
            wr_data = 32'h0000_00A0 + 32'(m_busy ? m_beats : 0);
            tick(c);
        end
        check("wr2_beats", 64'(obs_wr.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_wr.size(); i++)
            check("wr2_data", 64'(obs_wr[i]), 64'(32'hA0 + 32'(i)));
        check("wr2_done_count", 64'(done_cnt - base), 64'd1);
        check("wr2_done_cycles", 64'(h_done), 64'h0100);
        check("wr2_addr_stable", 64'(addr_bad), 64'd0);
        check("wr2_busy_cycles", 64'($countones(h_busy)), 64'd7);

        // Read 3 beats with a request stall and a data gap.
        idle_inputs();
        clear_hist();
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (c == 0); cmd_write = 1'b0; cmd_address = 16'h0020;
            cmd_burstcount = 5'd3;
            avm_waitrequest = (c == 1);
            avm_readdatavalid = (c == 3 || c == 4 || c == 6);
            avm_readdata = (c == 3) ? 32'h11 : (c == 4) ? 32'h22 : (c == 6) ? 32'h33 : 32'hDEAD;
            tick(c);
        end
        check("rd_read_cycles", 64'(h_read), 64'h0006);
        check("rd_begin_cycles", 64'(h_begin), 64'h0002);
        check("rd_valid_cycles", 64'(h_rdv), 64'h00B0);
        check("rd_done_cycles", 64'(h_done), 64'h0080);
        check("rd_err_cycles", 64'(h_err), 64'h0000);
        check("rd_beats", 64'(obs_rd.size()), 64'd3);
        if (obs_rd.size() == 3) begin
            check("rd_word0", 64'(obs_rd[0]), 64'h11);
            check("rd_word1", 64'(obs_rd[1]), 64'h22);
            check("rd_word2", 64'(obs_rd[2]), 64'h33);
        end

        // Illegal burst lengths.
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            clear_hist();
            for (int c = 0; c < 4; c++) begin
                cmd_valid = (c == 0); cmd_write = (k == 0); cmd_address = 16'h0099;
                cmd_burstcount = (k == 0) ? 5'd0 : 5'd17;
                tick(c);
            end
            check("ill_done_cycles", 64'(h_done), 64'h0002);
            check("ill_err_cycles", 64'(h_err), 64'h0002);
            check("ill_bus_activity", 64'(h_write | h_read), 64'h0000);
            check("ill_busy", 64'(h_busy), 64'h0000);
        end

        // Reset in the middle of an 8-beat read.
        idle_inputs();
        clear_hist();
        base = done_cnt;
        for (int c = 0; c < 4; c++) begin
            cmd_valid = (c == 0); cmd_write = 1'b0; cmd_address = 16'h0030;
            cmd_burstcount = 5'd8;
            avm_readdatavalid = (c >= 2); avm_readdata = 32'h100 + 32'(c);
            tick(c);
        end
        cmd_valid = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h104;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_no_done", 64'(done_cnt - base), 64'd0);
        clear_hist();
        for (int c = 0; c < 6; c++) begin
            cmd_valid = (c == 0); cmd_write = 1'b0; cmd_address = 16'h0040;
            cmd_burstcount = 5'd1;
            avm_readdatavalid = (c == 2); avm_readdata = 32'h5A;
            tick(c);
        end
        check("post_reset_done", 64'(h_done), 64'h0008);
        check("post_reset_rdv", 64'(h_rdv), 64'h0008);
        check("post_reset_beats", 64'(obs_rd.size()), 64'd1);
        if (obs_rd.size() == 1) check("post_reset_word", 64'(obs_rd[0]), 64'h5A);

`ifdef AVMM_BURST_MASTER_TIMEOUT_EN
        // Slave returns 2 of 4 beats then goes silent.
        idle_inputs();
        clear_hist();
        for (int c = 0; c < 16; c++) begin
            cmd_valid = (c == 0); cmd_write = 1'b0; cmd_address = 16'h0050;
            cmd_burstcount = 5'd4;
            avm_readdatavalid = (c == 2 || c == 3); avm_readdata = 32'h700 + 32'(c);
            tick(c);
        end
        check("to_rdv_cycles", 64'(h_rdv), 64'h0018);
        check("to_done_cycles", 64'(h_done), 64'h1000);
        check("to_err_cycles", 64'(h_err), 64'h1000);
        check("to_busy_cycles", 64'(h_busy), 64'h0FFE);
`endif

        // Randomized traffic, including commands while busy, illegal lengths
        // and stray readdatavalid strobes.
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_address = AW'($urandom);
            if ($urandom_range(0, 7) == 0)
                cmd_burstcount = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(17, 31));
            else
                cmd_burstcount = 5'($urandom_range(1, 16));
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data = $urandom;
            avm_waitrequest = ($urandom_range(0, 2) == 0);
            avm_readdatavalid = ($urandom_range(0, 4) < 3);
            avm_readdata = $urandom;
            tick(-1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
